// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - in-place radix-2 FFT address and control sequencer
module fft_sequencer #(
    parameter int N      = 16,
    parameter int BF_LAT = 3,
    localparam int AW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start_i,
    input  logic          abort_i,
    output logic          in_ready_o,
    output logic          in_sel_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr0_o,
    output logic [AW-1:0] rd_addr1_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr0_o,
    output logic [AW-1:0] wr_addr1_o,
    output logic [AW-2:0] twiddle_addr_o,
    output logic          bf_valid_o,
    output logic          fft_ready_o,
    output logic          done_o,
    output logic [2:0]    state_o,
    output logic [AW-1:0] stage_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_OUTPUT  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // One shared counter serves LOAD (k), COMPUTE (b), DRAIN and OUTPUT (m);
    // one extra bit lets it count a full drain even for the smallest N.
    localparam logic [AW:0]   LOAD_LAST  = (AW+1)'(N - 1);
    localparam logic [AW:0]   BF_LAST    = (AW+1)'(N / 2 - 1);
    localparam logic [AW:0]   DRAIN_LAST = (AW+1)'(BF_LAT - 1);
    localparam logic [AW-1:0] STAGE_LAST = AW'(AW - 1);

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] stage_q, stage_d;

    // Butterfly operand addresses for the next cycle
    logic [AW-1:0] b_w, span_w, pos_w, grp_w, a0_w, a1_w;
    logic [AW-2:0] tw_w;

    // Read-to-write delay line: one entry per cycle of butterfly latency
    logic [BF_LAT-1:0]         pv_q;
    logic [BF_LAT-1:0][AW-1:0] pa0_q;
    logic [BF_LAT-1:0][AW-1:0] pa1_q;

    // Registered outputs and their next values
    logic          load_d, bf_rd_d, out_rd_d, flush;
    logic          bf_rd_q, out_rd_q;
    logic          load_q, rd_en_q, wr_en_q, bf_valid_q, fft_ready_q, done_q;
    logic          wr_en_d;
    logic [AW-1:0] rd_addr0_d, rd_addr1_d, wr_addr0_d, wr_addr1_d;
    logic [AW-1:0] rd_addr0_q, rd_addr1_q, wr_addr0_q, wr_addr1_q;
    logic [AW-2:0] twiddle_d, twiddle_q;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    // Next-state logic: phase sequencing, counters and stage index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            S_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = S_COMPUTE;
                    cnt_d   = '0;
                    stage_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COMPUTE: begin
                if (cnt_q == BF_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        state_d = S_OUTPUT;
                    end else begin
                        state_d = S_COMPUTE;
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                stage_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                stage_d = '0;
            end
        endcase
        // Abort beats every other transition and forgets the whole transform
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            stage_d = '0;
        end
    end

    // Output next values, computed from the next state so the flops line up with state_o
    always_comb begin
        flush    = abort_i && (state_q != S_IDLE);
        load_d   = (state_d == S_LOAD);
        bf_rd_d  = (state_d == S_COMPUTE);
        out_rd_d = (state_d == S_OUTPUT);

        // a0 = grp*2*span + pos; a1 = a0 + span (bit s of a0 is always clear)
        b_w    = {1'b0, cnt_d[AW-2:0]};
        span_w = AW'(1) << stage_d;
        pos_w  = b_w & (span_w - AW'(1));
        grp_w  = b_w >> stage_d;
        a0_w   = (grp_w << (stage_d + AW'(1))) | pos_w;
        a1_w   = a0_w | span_w;
        tw_w   = pos_w[AW-2:0] << (AW'(AW - 1) - stage_d);

        rd_addr0_d = '0;
        rd_addr1_d = '0;
        twiddle_d  = '0;
        if (bf_rd_d) begin
            rd_addr0_d = a0_w;
            rd_addr1_d = a1_w;
            twiddle_d  = tw_w;
        end else if (out_rd_d) begin
            rd_addr0_d = cnt_d[AW-1:0];
        end

        wr_en_d    = load_d | (pv_q[BF_LAT-1] & ~flush);
        wr_addr0_d = '0;
        wr_addr1_d = '0;
        if (load_d) begin
            wr_addr0_d = bitrev(cnt_d[AW-1:0]);
        end else if (pv_q[BF_LAT-1] && !flush) begin
            wr_addr0_d = pa0_q[BF_LAT-1];
            wr_addr1_d = pa1_q[BF_LAT-1];
        end
    end

    // State, counter and stage registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end

    // Delay line shift; cleared on abort so no stale butterfly write escapes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv_q  <= '0;
            pa0_q <= '0;
            pa1_q <= '0;
        end else if (flush) begin
            pv_q  <= '0;
            pa0_q <= '0;
            pa1_q <= '0;
        end else begin
            pv_q[0]  <= bf_rd_d;
            pa0_q[0] <= a0_w;
            pa1_q[0] <= a1_w;
            for (int i = 1; i < BF_LAT; i++) begin
                pv_q[i]  <= pv_q[i-1];
                pa0_q[i] <= pa0_q[i-1];
                pa1_q[i] <= pa1_q[i-1];
            end
        end
    end

    // Output registers; bf_valid and fft_ready trail their reads by the RAM latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_q      <= 1'b0;
            bf_rd_q     <= 1'b0;
            out_rd_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            bf_valid_q  <= 1'b0;
            fft_ready_q <= 1'b0;
            done_q      <= 1'b0;
            rd_addr0_q  <= '0;
            rd_addr1_q  <= '0;
            wr_addr0_q  <= '0;
            wr_addr1_q  <= '0;
            twiddle_q   <= '0;
        end else begin
            load_q      <= load_d;
            bf_rd_q     <= bf_rd_d;
            out_rd_q    <= out_rd_d;
            rd_en_q     <= bf_rd_d | out_rd_d;
            wr_en_q     <= wr_en_d;
            bf_valid_q  <= bf_rd_q;
            fft_ready_q <= out_rd_q;
            done_q      <= (state_d == S_DONE);
            rd_addr0_q  <= rd_addr0_d;
            rd_addr1_q  <= rd_addr1_d;
            wr_addr0_q  <= wr_addr0_d;
            wr_addr1_q  <= wr_addr1_d;
            twiddle_q   <= twiddle_d;
        end
    end

    assign in_ready_o     = load_q;
    assign in_sel_o       = load_q;
    assign rd_en_o        = rd_en_q;
    assign rd_addr0_o     = rd_addr0_q;
    assign rd_addr1_o     = rd_addr1_q;
    assign wr_en_o        = wr_en_q;
    assign wr_addr0_o     = wr_addr0_q;
    assign wr_addr1_o     = wr_addr1_q;
    assign twiddle_addr_o = twiddle_q;
    assign bf_valid_o     = bf_valid_q;
    assign fft_ready_o    = fft_ready_q;
    assign done_o         = done_q;
    assign state_o        = state_q;
    assign stage_o        = stage_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - self-checking bench for fft_sequencer with a schedule model
module tb_fft_sequencer;

    localparam int N  = 16;
    localparam int L  = 3;
    localparam int AW = 4;
    localparam int P  = N / 2 + L;
    localparam int OS = N + AW * P + 1;
    localparam int DS = OS + N;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          in_ready_o, in_sel_o, rd_en_o, wr_en_o;
    logic          bf_valid_o, fft_ready_o, done_o;
    logic [AW-1:0] rd_addr0_o, rd_addr1_o, wr_addr0_o, wr_addr1_o, stage_o;
    logic [AW-2:0] twiddle_addr_o;
    logic [2:0]    state_o;

    fft_sequencer #(.N(N), .BF_LAT(L)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .in_ready_o     (in_ready_o),
        .in_sel_o       (in_sel_o),
        .rd_en_o        (rd_en_o),
        .rd_addr0_o     (rd_addr0_o),
        .rd_addr1_o     (rd_addr1_o),
        .wr_en_o        (wr_en_o),
        .wr_addr0_o     (wr_addr0_o),
        .wr_addr1_o     (wr_addr1_o),
        .twiddle_addr_o (twiddle_addr_o),
        .bf_valid_o     (bf_valid_o),
        .fft_ready_o    (fft_ready_o),
        .done_o         (done_o),
        .state_o        (state_o),
        .stage_o        (stage_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        int st;
        int stage;
        bit rd;
        bit bfrd;
        bit outrd;
        int a0;
        int a1;
        int tw;
        bit load;
        int wa0;
        bit done;
    } exp_t;

    function automatic int bit_reverse(input int v);
        int r = 0;
        for (int i = 0; i < AW; i++) begin
            if (((v >> i) & 1) != 0) r = r | (1 << (AW - 1 - i));
        end
        return r;
    endfunction

    // Expected outputs at 'mt' cycles after the cycle start was accepted
    function automatic exp_t model_at(input int mt);
        exp_t e;
        int r, s, q, span, pos, grp;
        e = '{default: 0};
        if (mt == 0) begin
            e.st = 0;
        end else if (mt <= N) begin
            e.st   = 1;
            e.load = 1;
            e.wa0  = bit_reverse(mt - 1);
        end else if (mt < OS) begin
            r = mt - (N + 1);
            s = r / P;
            q = r % P;
            e.stage = s;
            if (q < N / 2) begin
                e.st   = 2;
                e.rd   = 1;
                e.bfrd = 1;
                span   = 1 << s;
                pos    = q % span;
                grp    = q / span;
                e.a0   = grp * 2 * span + pos;
                e.a1   = e.a0 + span;
                e.tw   = pos << (AW - 1 - s);
            end else begin
                e.st = 3;
            end
        end else if (mt < DS) begin
            e.st    = 4;
            e.rd    = 1;
            e.outrd = 1;
            e.a0    = mt - OS;
        end else begin
            e.st   = 5;
            e.done = 1;
        end
        return e;
    endfunction

    // Per-cycle comparison against the model
    int mt = 0;
    bit prev_bf = 0;
    bit prev_out = 0;
    int sched_a0[int];
    int sched_a1[int];
    exp_t e;
    bit ew;

    always @(negedge clk) begin
        if (!rstn) begin
            chk("reset_ctrl", int'({state_o, rd_en_o, wr_en_o, in_ready_o, in_sel_o,
                                     bf_valid_o, fft_ready_o, done_o}), 0);
            chk("reset_addr", int'({rd_addr0_o, rd_addr1_o, wr_addr0_o, wr_addr1_o,
                                     twiddle_addr_o, stage_o}), 0);
            mt = 0;
            prev_bf = 0;
            prev_out = 0;
            sched_a0.delete();
            sched_a1.delete();
        end else begin
            e = model_at(mt);
            chk("state", state_o, e.st);
            if (e.st == 2 || e.st == 3) chk("stage", stage_o, e.stage);
            chk("rd_en", rd_en_o, e.rd);
            if (e.rd) chk("rd_addr0", rd_addr0_o, e.a0);
            if (e.bfrd) begin
                chk("rd_addr1", rd_addr1_o, e.a1);
                chk("twiddle", twiddle_addr_o, e.tw);
            end
            ew = e.load || sched_a0.exists(cyc);
            chk("wr_en", wr_en_o, ew);
            if (e.load) begin
                chk("load_wr_addr0", wr_addr0_o, e.wa0);
                chk("load_wr_addr1", wr_addr1_o, 0);
            end else if (sched_a0.exists(cyc)) begin
                chk("bf_wr_addr0", wr_addr0_o, sched_a0[cyc]);
                chk("bf_wr_addr1", wr_addr1_o, sched_a1[cyc]);
                sched_a0.delete(cyc);
                sched_a1.delete(cyc);
            end
            chk("in_ready", in_ready_o, e.load);
            chk("in_sel", in_sel_o, e.load);
            chk("bf_valid", bf_valid_o, prev_bf);
            chk("fft_ready", fft_ready_o, prev_out);
            chk("done", done_o, e.done);
            prev_bf = e.bfrd;
            prev_out = e.outrd;
            if (e.bfrd) begin
                sched_a0[cyc + L] = e.a0;
                sched_a1[cyc + L] = e.a1;
            end
            if (mt == 0) begin
                if (start_i && !abort_i) mt = 1;
            end else if (abort_i) begin
                mt = 0;
                sched_a0.delete();
                sched_a1.delete();
            end else if (mt == DS) begin
                mt = 0;
            end else begin
                mt++;
            end
        end
    end

    // Directed-run captures
    int ld_seq[N];
    int ld_ref[N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int ld_n;
    int s1_a0, s1_a1, s1_tw, s1_wen, s1_w0, s1_w1;
    int ab_state, ab_stage, post_ab_state, rst_any;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_tx(input int abort_rel, input int rst_rel, input int cycles,
                          output int done_rel, output int ready_cnt,
                          output int wr_late, output int done_late);
        done_rel = -1;
        ready_cnt = 0;
        wr_late = 0;
        done_late = 0;
        ld_n = 0;
        start_i = 1'b1;
        for (int rel = 0; rel < cycles; rel++) begin
            abort_i = (rel == abort_rel);
            if (rel == rst_rel) rstn = 1'b0;
            @(negedge clk);
            if (state_o == 3'd1 && ld_n < N) begin
                ld_seq[ld_n] = wr_addr0_o;
                ld_n++;
            end
            if (rel == 31) begin
                s1_a0 = rd_addr0_o;
                s1_a1 = rd_addr1_o;
                s1_tw = twiddle_addr_o;
            end
            if (rel == 34) begin
                s1_wen = wr_en_o;
                s1_w0 = wr_addr0_o;
                s1_w1 = wr_addr1_o;
            end
            if (rel == abort_rel) begin
                ab_state = state_o;
                ab_stage = stage_o;
            end
            if (abort_rel >= 0 && rel == abort_rel + 1) post_ab_state = state_o;
            if (rel == rst_rel) begin
                rst_any = int'({rd_en_o, wr_en_o, in_ready_o, in_sel_o, bf_valid_o,
                                fft_ready_o, done_o, state_o, stage_o,
                                rd_addr0_o, rd_addr1_o, wr_addr0_o, wr_addr1_o} != 0);
            end
            if (fft_ready_o) ready_cnt++;
            if (done_o && done_rel < 0) done_rel = rel;
            if (abort_rel >= 0 && rel > abort_rel) begin
                wr_late += int'(wr_en_o);
                done_late += int'(done_o);
            end
            tick();
            start_i = 1'b0;
            abort_i = 1'b0;
            if (rel == rst_rel) rstn = 1'b1;
        end
    endtask

    int dr, rc, wl, dl;
    int first_d, second_d, dcount;

    initial begin
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        repeat (2) tick();

        // Full transform: load order, stage-1 butterfly, latency, output count
        run_tx(-1, -1, 90, dr, rc, wl, dl);
        chk("load_count", ld_n, N);
        for (int i = 0; i < N; i++) chk("load_bitrev_seq", ld_seq[i], ld_ref[i]);
        chk("s1_b3_rd_addr0", s1_a0, 5);
        chk("s1_b3_rd_addr1", s1_a1, 7);
        chk("s1_b3_twiddle", s1_tw, 4);
        chk("s1_b3_wr_en", s1_wen, 1);
        chk("s1_b3_wr_addr0", s1_w0, 5);
        chk("s1_b3_wr_addr1", s1_w1, 7);
        chk("done_cycle", dr, 77);
        chk("fft_ready_cycles", rc, 16);

        // Abort in stage 2 drain
        run_tx(48, -1, 100, dr, rc, wl, dl);
        chk("abort_at_state", ab_state, 3);
        chk("abort_at_stage", ab_stage, 2);
        chk("abort_next_state", post_ab_state, 0);
        chk("abort_late_writes", wl, 0);
        chk("abort_late_done", dl, 0);
        chk("abort_no_done", dr, -1);

        // Reset in the middle of COMPUTE, then a clean run
        run_tx(-1, 20, 30, dr, rc, wl, dl);
        chk("reset_mid_outputs", rst_any, 0);
        chk("reset_mid_no_done", dr, -1);
        run_tx(-1, -1, 90, dr, rc, wl, dl);
        chk("after_reset_done_cycle", dr, 77);
        chk("after_reset_ready_cycles", rc, 16);

        // start held high: back-to-back transforms through IDLE
        start_i = 1'b1;
        first_d = -1;
        second_d = -1;
        dcount = 0;
        for (int rel = 0; rel < 260; rel++) begin
            @(negedge clk);
            if (done_o) begin
                dcount++;
                if (first_d < 0) first_d = rel;
                else if (second_d < 0) second_d = rel;
            end
            tick();
            if (rel == 99) start_i = 1'b0;
        end
        chk("hold_first_done", first_d, 77);
        chk("hold_second_done", second_d, 155);
        chk("hold_done_count", dcount, 2);

        // abort and start together in IDLE
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        @(negedge clk);
        chk("idle_abort_wins", state_o, 0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start_i = ($urandom_range(0, 5) == 0);
            abort_i = ($urandom_range(0, 249) == 0);
            rstn    = ($urandom_range(0, 599) != 0);
            tick();
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        rstn = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 Parameter N, default 16: FFT length, power of two, 4..1024; AW = log2(N).
REQ-002 Parameter BF_LAT, default 3: butterfly pipeline latency in cycles, 1..8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  begin one transform; sampled only in IDLE.
REQ-006 abort_i  input  1  synchronous abandon of the current transform.
REQ-007 in_ready_o  output  1  high in LOAD; the external sample is written this cycle.
REQ-008 in_sel_o  output  1  RAM write-data mux: 1 = external input, 0 = butterfly result.
REQ-009 rd_en_o, rd_addr0_o[AW-1:0], rd_addr1_o[AW-1:0]  output  read port enable and butterfly operand addresses.
REQ-010 wr_en_o, wr_addr0_o[AW-1:0], wr_addr1_o[AW-1:0]  output  write port enable and addresses.
REQ-011 twiddle_addr_o  output  AW-1  twiddle ROM index, aligned with rd_en_o.
REQ-012 bf_valid_o  output  1  butterfly operands valid; this is rd_en_o delayed by 1 cycle (RAM read latency).
REQ-013 fft_ready_o  output  1  result sample valid on the RAM read data, natural order.
REQ-014 done_o  output  1  one-cycle pulse at the end of a transform.
REQ-015 state_o  output  3  current state encoding; stage_o  output  AW bits  current stage.

Function
REQ-016 State encoding: IDLE=0, LOAD=1, COMPUTE=2, DRAIN=3, OUTPUT=4, DONE=5.
REQ-017 IDLE->LOAD on start_i=1; start_i in any other state is ignored.
REQ-018 LOAD: N cycles, counter k=0..N-1; wr_en_o=1, in_sel_o=1, wr_addr0_o=bitrev(k); wr_addr1_o unused (driven 0); then ->COMPUTE with stage s=0.
REQ-019 COMPUTE: N/2 cycles, butterfly b=0..N/2-1, one per cycle.
  - Span = 2^s, pos = b mod span, grp = b>>s.
  - rd_addr0 = grp*2*span+pos; rd_addr1 = rd_addr0+span; twiddle = pos<<(AW-1-s).
REQ-020 Each issued read pushes {addr0, addr1} into a BF_LAT-deep delay line; the write (wr_en_o=1, in_sel_o=0) occurs BF_LAT cycles after the read cycle, to the same addresses.
REQ-021 After the last butterfly of a stage ->DRAIN for exactly BF_LAT cycles, guaranteeing the last write precedes the next stage's first read.
REQ-022 DRAIN exit: ->COMPUTE with s+1 if s<AW-1, else ->OUTPUT.
REQ-023 OUTPUT: N cycles, rd_en_o=1, rd_addr0_o=m for m=0..N-1; fft_ready_o is rd_en_o delayed 1 cycle, so high for N cycles ending 1 cycle after OUTPUT; then ->DONE.
REQ-024 DONE: one cycle, done_o=1, ->IDLE; the trailing fft_ready_o cycle coincides with DONE.
REQ-025 Latency for N=16, BF_LAT=3: start sampled at cycle 0, LOAD cycles 1-16, COMPUTE/DRAIN cycles 17-60 (4x(8+3)), OUTPUT cycles 61-76, DONE at cycle 77.
REQ-026 abort_i=1 in any non-IDLE state: ->IDLE next cycle; delay line cleared; no further wr_en_o; no done_o.
REQ-027 abort_i and start_i both high in IDLE: abort wins; stay IDLE.
REQ-028 Counters wrap exactly at their limits; no address ever exceeds N-1.
REQ-029 Outputs are registered.

Reset
REQ-030 rstn=0 forces, asynchronously:
  - state IDLE, all counters and stage_o 0, delay line empty;
  - all enables, in_ready_o, in_sel_o, bf_valid_o, fft_ready_o, done_o 0;
  - all addresses 0.
REQ-031 Reset mid-transform discards all progress; the next start_i restarts from LOAD.

Verification
REQ-032 N=16, start pulse -> wr_addr0_o sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 during LOAD.
REQ-033 Stage 1, b=3 -> rd_addr0=5, rd_addr1=7, twiddle_addr=4; matching write 3 cycles later to 5/7.
REQ-034 Full run -> done_o at cycle 77, fft_ready_o high exactly 16 cycles, addresses 0..15.
REQ-035 abort_i during stage 2 DRAIN -> state IDLE next cycle, no wr_en_o afterwards, no done_o.
REQ-036 rstn low during COMPUTE -> all outputs 0 immediately; subsequent start completes normally at cycle 77.
REQ-037 start_i held high through the run -> exactly one transform; a second starts only if start_i is still high in IDLE after DONE.
